// File: rtl/blake_output_processing.sv
// Output stage for a finished BLAKE digest: captures one digest, byte-reverses each word
// and streams the words out over a valid/ready handshake, word 0 first.
module blake_output_processing #(
    parameter int unsigned DIGEST_W = 512,
    parameter int unsigned WORD_W   = 32,
    localparam int unsigned NWORDS  = DIGEST_W / WORD_W,
    localparam int unsigned IDX_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIGEST_W-1:0] digest_in,
    input  logic                digest_valid,
    output logic                digest_ready,
    output logic [WORD_W-1:0]   dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic [IDX_W-1:0]    word_idx,
    output logic                busy
);

    localparam int unsigned NBYTES = WORD_W / 8;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NWORDS - 1);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    state_e                state_q, state_d;
    logic [DIGEST_W-1:0]   hold_q, hold_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic                  send;
    logic                  digest_hs;
    logic [WORD_W-1:0]     cur_word;
    logic [WORD_W-1:0]     swapped;

    assign send = (state_q == StSend);

    // Select the held word and reverse its byte order.
    always_comb begin
        cur_word = hold_q[idx_q*WORD_W +: WORD_W];
        swapped  = '0;
        for (int j = 0; j < int'(NBYTES); j++) begin
            swapped[8*j +: 8] = cur_word[8*(int'(NBYTES)-1-j) +: 8];
        end
    end

    assign dout_valid   = send;
    assign busy         = send;
    assign dout_last    = send && (idx_q == LastIdx);
    assign dout         = send ? swapped : '0;
    assign word_idx     = idx_q;
    // Ready during the last-word handshake lets a new digest follow with no bubble.
    assign digest_ready = !send || (dout_last && dout_ready);
    assign digest_hs    = digest_valid && digest_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (digest_valid) begin
                    state_d = StSend;
                    idx_d   = '0;
                end
            end
            StSend: begin
                if (dout_ready) begin
                    if (!dout_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        idx_d = '0;
                        if (!digest_valid) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
        if (digest_hs) begin
            hold_d = digest_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
        end
    end

endmodule
